idli_sqi_ram_m: RTL and testbench

Parametrised behavioural model of a quad-SPI (SQI) serial SRAM for simulation and FPGA bring-up, sitting on the idli SQI bus in place of an external 23LC1024/25LC512-class part. Extends the single-mode 25LC512 model with:
- configurable size, address width and dummy length;
- a mode register (byte / page / sequential) with RDMR/WRMR;
- page and array wrap-around;
- atomic byte writes;
- an explicit output enable;
- asynchronous reset.

---
 rtl/idli_pkg.sv | 40 ++++
 rtl/idli_sqi_ram_m.sv | 164 ++++++++++++++++
 tb/tb_idli_sqi_ram_m.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli SQI bus and the SQI serial SRAM model.
package idli_pkg;

    // One nibble of the quad SIO bus.
    typedef logic [3:0] slice_t;

    // Opcodes understood by the SRAM model.
    typedef enum logic [7:0] {
        SQI_WRMR  = 8'h01,
        SQI_WRITE = 8'h02,
        SQI_READ  = 8'h03,
        SQI_RDMR  = 8'h05
    } sqi_instr_t;

    // Mode register bits [7:6]; 2'b11 is not named and behaves as BYTE.
    typedef enum logic [1:0] {
        SQI_MODE_BYTE = 2'b00,
        SQI_MODE_SEQ  = 2'b01,
        SQI_MODE_PAGE = 2'b10
    } sqi_mode_t;

    // Transaction phases seen by the SRAM.
    typedef enum logic [2:0] {
        SQI_INSTR,
        SQI_ADDR,
        SQI_DUMMY,
        SQI_DATA_HI,
        SQI_DATA_LO,
        SQI_IGNORE
    } sqi_state_t;

    // Mode the part wakes up in after reset.
    localparam logic [1:0] SQI_MODE_RESET = SQI_MODE_SEQ;

    // True when a data phase keeps going byte after byte.
    function automatic logic sqi_mode_streams(input logic [1:0] mode);
        return (mode == SQI_MODE_SEQ) || (mode == SQI_MODE_PAGE);
    endfunction

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Behavioural quad-SPI serial SRAM sitting on the idli SQI bus.
// Accepts READ/WRITE/RDMR/WRMR, supports byte, page and sequential modes,
// and only commits a written byte once both nibbles have arrived.
module idli_sqi_ram_m
    import idli_pkg::*;
#(
    parameter int SIZE          = 65536,
    parameter int ADDR_BYTES    = 2,
    parameter int PAGE_BYTES    = 32,
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_sqi_cs,
    input  slice_t i_sqi_sio,
    output slice_t o_sqi_sio,
    output logic   o_sqi_oe
);

    localparam int AW           = $clog2(SIZE);
    localparam int ADDR_NIBBLES = 2 * ADDR_BYTES;
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);

    sqi_state_t    state;
    logic [7:0]    cnt;
    logic [7:0]    opcode;
    logic [AW-1:0] addr;
    slice_t        hi_nib;
    logic [1:0]    mode;

    logic [7:0]    mem [SIZE];

    logic [7:0]    instr_full;
    logic [7:0]    data_byte;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] addr_adv;
    logic          is_mode_cmd;
    logic          is_drive_cmd;
    logic          mem_we;
    logic [7:0]    out_byte;
    slice_t        drive_nib;
    logic          drive_oe;

    assign instr_full   = {opcode[7:4], i_sqi_sio};
    assign data_byte    = {hi_nib, i_sqi_sio};
    assign addr_inc     = addr + AW'(1);
    assign is_mode_cmd  = (opcode == SQI_RDMR) || (opcode == SQI_WRMR);
    assign is_drive_cmd = (opcode == SQI_READ) || (opcode == SQI_RDMR);
    assign mem_we       = !i_sqi_cs && (state == SQI_DATA_LO) && (opcode == SQI_WRITE);
    assign out_byte     = (opcode == SQI_RDMR) ? {mode, 6'b0} : mem[addr];

    // Next data address: sequential wraps the whole array, page wraps inside the page.
    always_comb begin
        addr_adv = addr;
        case (mode)
            SQI_MODE_SEQ:  addr_adv = addr_inc;
            SQI_MODE_PAGE: addr_adv = (addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
            default:       addr_adv = addr;
        endcase
    end

    // Command sequencer: opcode, address, dummy and data nibbles, with CS abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= SQI_INSTR;
            cnt    <= '0;
            opcode <= '0;
            addr   <= '0;
            hi_nib <= '0;
            mode   <= SQI_MODE_RESET;
        end else if (i_sqi_cs) begin
            state  <= SQI_INSTR;
            cnt    <= '0;
            hi_nib <= '0;
        end else begin
            case (state)
                SQI_INSTR: begin
                    if (cnt == 8'd0) begin
                        opcode <= {i_sqi_sio, 4'h0};
                        cnt    <= 8'd1;
                    end else begin
                        opcode <= instr_full;
                        cnt    <= '0;
                        case (instr_full)
                            SQI_READ, SQI_WRITE: state <= SQI_ADDR;
                            SQI_RDMR, SQI_WRMR:  state <= SQI_DATA_HI;
                            default:             state <= SQI_IGNORE;
                        endcase
                    end
                end
                SQI_ADDR: begin
                    addr <= AW'({addr, i_sqi_sio});
                    if (cnt == 8'(ADDR_NIBBLES - 1)) begin
                        cnt <= '0;
                        if ((opcode == SQI_READ) && (DUMMY_NIBBLES != 0)) begin
                            state <= SQI_DUMMY;
                        end else begin
                            state <= SQI_DATA_HI;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SQI_DUMMY: begin
                    if (cnt == 8'(DUMMY_NIBBLES - 1)) begin
                        cnt   <= '0;
                        state <= SQI_DATA_HI;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SQI_DATA_HI: begin
                    hi_nib <= i_sqi_sio;
                    state  <= SQI_DATA_LO;
                end
                SQI_DATA_LO: begin
                    if (opcode == SQI_WRMR) begin
                        mode <= data_byte[7:6];
                    end
                    if (is_mode_cmd || !sqi_mode_streams(mode)) begin
                        state <= SQI_IGNORE;
                    end else begin
                        addr  <= addr_adv;
                        state <= SQI_DATA_HI;
                    end
                end
                default: state <= SQI_IGNORE;
            endcase
        end
    end

    // Array write: a byte lands only when its low nibble is sampled.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[addr] <= data_byte;
        end
    end

    // Output drive: dummy nibbles are don't-care, data phases drive memory or mode.
    always_comb begin
        drive_nib = 'x;
        drive_oe  = 1'b0;
        case (state)
            SQI_DUMMY: drive_oe = 1'b1;
            SQI_DATA_HI: begin
                if (is_drive_cmd) begin
                    drive_oe  = 1'b1;
                    drive_nib = out_byte[7:4];
                end
            end
            SQI_DATA_LO: begin
                if (is_drive_cmd) begin
                    drive_oe  = 1'b1;
                    drive_nib = out_byte[3:0];
                end
            end
            default: drive_oe = 1'b0;
        endcase
    end

    assign o_sqi_oe  = drive_oe;
    assign o_sqi_sio = drive_oe ? drive_nib : 'z;

endmodule

// File: tb/tb_idli_sqi_ram_m.sv
// Scoreboard bench for the SQI SRAM model: directed scenarios followed by
// random transactions, checked against a byte-array reference of the part.
module tb_idli_sqi_ram_m;

    localparam int SIZE          = 65536;
    localparam int ADDR_BYTES    = 2;
    localparam int PAGE_BYTES    = 32;
    localparam int DUMMY_NIBBLES = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs    = 1'b1;
    logic [3:0] sio_in = 4'h0;
    wire  [3:0] sio_out;
    wire        oe;

    typedef struct {
        bit         care;
        logic [3:0] nib;
        string      tag;
    } exp_t;

    exp_t       sb [$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_mem [int];
    logic [1:0] model_mode = 2'b01;

    idli_sqi_ram_m #(
        .SIZE(SIZE),
        .ADDR_BYTES(ADDR_BYTES),
        .PAGE_BYTES(PAGE_BYTES),
        .DUMMY_NIBBLES(DUMMY_NIBBLES)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_sqi_cs(cs),
        .i_sqi_sio(sio_in),
        .o_sqi_sio(sio_out),
        .o_sqi_oe(oe)
    );

    // Free-running SCK.
    always #5 clk = ~clk;

    // Monitor: every nibble the part drives is matched against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && oe === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_oe: got oe=1 required oe=0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (e.care) begin
                    total++;
                    if (sio_out !== e.nib) begin
                        bad++;
                        $display("[TB] FAIL %s: got %h required %h at %0t", e.tag, sio_out, e.nib, $time);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: next address from the mode rules.
    function automatic int adv(input int a);
        if (model_mode == 2'b01) return (a + 1) % SIZE;
        if (model_mode == 2'b10) return (a / PAGE_BYTES) * PAGE_BYTES + ((a % PAGE_BYTES) + 1) % PAGE_BYTES;
        return a;
    endfunction

    function automatic bit streams();
        return (model_mode == 2'b01) || (model_mode == 2'b10);
    endfunction

    function automatic void push(input bit care, input logic [3:0] nib, input string tag);
        exp_t e;
        e.care = care;
        e.nib  = nib;
        e.tag  = tag;
        sb.push_back(e);
    endfunction

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        cs     = 1'b0;
        sio_in = n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic send_addr(input int a);
        for (int k = 2 * ADDR_BYTES - 1; k >= 0; k--) begin
            send_nib(4'((a >> (4 * k)) & 15));
        end
    endtask

    task automatic check_output(input string tag, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %b required %b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_oe_low(input string tag);
        check_output(tag, oe, 1'b0);
    endtask

    task automatic end_txn();
        @(negedge clk);
        cs     = 1'b1;
        sio_in = 4'($urandom());
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL txn_drain: got %0d pending nibbles required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic write_txn(input int addr, input int n, input logic [31:0] data);
        int         a;
        logic [7:0] b;
        a = addr;
        send_byte(8'h02);
        send_addr(addr);
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            send_byte(b);
            if (i == 0 || streams()) begin
                model_mem[a] = b;
                a = adv(a);
            end
        end
        end_txn();
    endtask

    task automatic fill(input int addr, input int n);
        for (int i = 0; i < n; i += 4) begin
            write_txn((addr + i) % SIZE, 4, $urandom());
        end
    endtask

    task automatic read_open(input int addr, input int n, input string tag);
        int         a;
        logic [7:0] b;
        a = addr;
        for (int d = 0; d < DUMMY_NIBBLES; d++) push(1'b0, 4'h0, "dummy");
        for (int i = 0; i < n; i++) begin
            if (i > 0 && !streams()) break;
            if (model_mem.exists(a)) begin
                b = model_mem[a];
                push(1'b1, b[7:4], tag);
                push(1'b1, b[3:0], tag);
            end else begin
                push(1'b0, 4'h0, tag);
                push(1'b0, 4'h0, tag);
            end
            a = adv(a);
        end
        send_byte(8'h03);
        send_addr(addr);
        for (int d = 0; d < DUMMY_NIBBLES; d++) send_nib(4'($urandom()));
        for (int k = 0; k < 2 * n - 1; k++) send_nib(4'($urandom()));
    endtask

    task automatic read_txn(input int addr, input int n, input string tag);
        read_open(addr, n, tag);
        end_txn();
    endtask

    task automatic rdmr_txn(input string tag);
        push(1'b1, {model_mode, 2'b00}, tag);
        push(1'b1, 4'h0, tag);
        send_byte(8'h05);
        send_nib(4'($urandom()));
        end_txn();
    endtask

    task automatic wrmr_txn(input logic [7:0] b);
        send_byte(8'h01);
        send_byte(b);
        model_mode = b[7:6];
        end_txn();
    endtask

    // Stimulus: directed scenarios, then a random mix of all four commands.
    initial begin
        int         a;
        int         n;
        logic [7:0] b;

        rst_n = 1'b0;
        cs    = 1'b1;
        repeat (2) @(negedge clk);
        check_oe_low("reset_oe");
        rst_n = 1'b1;
        model_mode = 2'b01;
        rdmr_txn("rdmr_reset");

        fill(16'hFFF0, 'h60);
        fill(16'h0100, 16);
        fill(16'h0200, 16);
        write_txn(16'h0200, 1, 32'h0000_0012);

        write_txn(16'hFFFF, 2, 32'h0000_3CA5);
        read_txn(16'hFFFF, 2, "seq_wrap");

        wrmr_txn(8'h80);
        rdmr_txn("rdmr_page");
        write_txn(16'h001F, 2, 32'h0000_2211);
        wrmr_txn(8'h40);
        read_txn(16'h001F, 2, "page_1f_20");
        read_txn(16'h0000, 1, "page_00");

        wrmr_txn(8'h00);
        write_txn(16'h0100, 2, 32'h0000_6655);
        read_open(16'h0100, 2, "byte_rd");
        send_nib(4'h0);
        check_oe_low("byte_rd_stop");
        end_txn();
        wrmr_txn(8'h40);
        read_txn(16'h0100, 2, "byte_seq_rd");

        send_byte(8'h02);
        send_addr(16'h0200);
        send_nib(4'hF);
        end_txn();
        read_txn(16'h0200, 1, "abort_rd");

        send_byte(8'hFF);
        for (int k = 0; k < 4; k++) begin
            send_nib(4'($urandom()));
            check_oe_low("illegal_oe");
        end
        end_txn();
        rdmr_txn("rdmr_after_illegal");

        wrmr_txn(8'hC0);
        rdmr_txn("rdmr_mode11");
        write_txn(16'h0104, 2, 32'h0000_BBAA);
        wrmr_txn(8'h40);
        read_txn(16'h0104, 2, "mode11_rd");

        wrmr_txn(8'h80);
        for (int d = 0; d < DUMMY_NIBBLES; d++) push(1'b0, 4'h0, "dummy");
        b = model_mem[16'h0010];
        push(1'b1, b[7:4], "reset_rd_hi");
        send_byte(8'h03);
        send_addr(16'h0010);
        for (int d = 0; d < DUMMY_NIBBLES; d++) send_nib(4'($urandom()));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_oe_low("reset_mid_oe");
        cs = 1'b1;
        sb.delete();
        model_mode = 2'b01;
        #1;
        rst_n = 1'b1;
        rdmr_txn("rdmr_after_reset");

        for (int t = 0; t < 60; t++) begin
            a = (16'hFFF0 + int'($urandom_range(0, 'h4F))) % SIZE;
            n = int'($urandom_range(1, 4));
            case ($urandom_range(0, 5))
                0, 1: write_txn(a, n, $urandom());
                2, 3: read_txn(a, n, "rand_rd");
                4:    wrmr_txn(8'($urandom()));
                default: rdmr_txn("rand_rdmr");
            endcase
        end

        wrmr_txn(8'h40);
        read_txn(16'hFFF8, 4, "final_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
